divu_hilo: RTL and testbench
============================

DIVU_HILO -- requirements
Module: divu_hilo

Interface
REQ-001 Parameter: DIVU, 6'b011011, function code that starts an unsigned divide.
REQ-002 Parameter: ITER, 32, number of iteration cycles per divide.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 dataA  input  32  dividend, unsigned.
REQ-006 dataB  input  32  divisor, unsigned.
REQ-007 Signal  input  6  instruction function code; DIVU starts a divide.
REQ-008 HiOut  output  32  registered remainder, feeds the writeback select stage.
REQ-009 LoOut  output  32  registered quotient, feeds the writeback select stage.
REQ-010 busy  output  1  high while a divide is in progress.
REQ-011 done  output  1  one-cycle pulse when HiOut/LoOut receive a new result.
REQ-012 divByZero  output  1  sticky flag, set by the last divide if its divisor was 0.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and FIN; the reset state is IDLE.
REQ-014 IDLE: on an edge with Signal==DIVU and dataB!=0, the block SHALL latch dataA/dataB, load the 64-bit work register with {32'b0, dataA}, clear the 6-bit counter, set busy, clear divByZero, and go to CALC (accept edge E).
REQ-015 IDLE: on an edge with Signal==DIVU and dataB==0, the block SHALL write HiOut=dataA and LoOut=32'hFFFFFFFF, set divByZero and pulse done for the next cycle; it SHALL stay in IDLE with busy low.
REQ-016 Each CALC edge SHALL perform one restoring step: shift the work register left 1; if upper32 >= divisor (33-bit unsigned compare), upper32 -= divisor and bit0 = 1, else bit0 = 0.
REQ-017 The counter SHALL increment each CALC edge; on the edge that completes step ITER (edge E+32), the FSM SHALL go to FIN.
REQ-018 On edge E+32, the block SHALL write HiOut = final upper32 (remainder) and LoOut = final lower32 (quotient), set done and clear busy.
REQ-019 FIN: done SHALL remain high for exactly one cycle; on edge E+33 the block SHALL clear done and return to IDLE.
REQ-020 Total latency SHALL be fixed at 32 cycles from the accept edge to the result, independent of the operand values.
REQ-021 Signal==DIVU seen in CALC or FIN SHALL be ignored; it SHALL NOT be queued, and the operands latched at acceptance SHALL NOT change.
REQ-022 Changes on dataA/dataB after acceptance SHALL NOT affect the result in progress.
REQ-023 HiOut/LoOut SHALL hold their values at all times except at a result write (REQ-015, REQ-018) or reset; MFHI, MFLO and other codes SHALL NOT modify them.
REQ-024 Signal==DIVU in IDLE on the edge where FIN returns to IDLE SHALL NOT be accepted; the earliest new accept is edge E+34.
REQ-025 No signed handling; all arithmetic SHALL be unsigned modulo 2^32.

Reset
REQ-026 When reset is asserted, the block SHALL immediately, with no clock, force state=IDLE, HiOut=0, LoOut=0, busy=0, done=0, divByZero=0, counter=0 and work register=0.
REQ-027 Reset asserted mid-CALC SHALL abort the divide with no partial result visible; after release the block SHALL accept a new DIVU on the first edge.

Verification
REQ-028 dataA=100, dataB=7, DIVU at edge E -> busy=1 from E to E+32; at E+32 HiOut=2, LoOut=14, done=1 for one cycle; divByZero=0.
REQ-029 dataA=32'hFFFFFFFF, dataB=1 -> LoOut=32'hFFFFFFFF, HiOut=0 at E+32; also dataA=3, dataB=10 -> HiOut=3, LoOut=0.
REQ-030 dataA=5, dataB=0, DIVU -> next cycle HiOut=5, LoOut=32'hFFFFFFFF, done=1, divByZero=1, busy=0; a following 9/3 divide -> HiOut=0, LoOut=3, divByZero=0.
REQ-031 Start 100/7, then reassert DIVU with 50/5 at E+5 and change dataA at E+10 -> result is still 2/14 at E+32; no second done pulse.
REQ-032 Start 100/7, assert reset asynchronously between edges E+10 and E+11 -> all outputs 0 at once; after release a 20/6 divide gives HiOut=2, LoOut=3.
REQ-033 MFHI/MFLO/ADD codes applied in IDLE after a result -> HiOut/LoOut unchanged, done stays 0.

Source files
------------

// File: rtl/divu_hilo.sv
// Unsigned 32/32 restoring divider writing the remainder to HiOut and the quotient to LoOut.
// Fixed 32-cycle latency from acceptance; a zero divisor completes in one cycle; DIVU while busy is dropped.
module divu_hilo #(
  parameter logic [5:0] DIVU = 6'b011011,
  parameter int         ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic        busy,
  output logic        done,
  output logic        divByZero
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  localparam logic [5:0] LAST = 6'(ITER - 1);

  state_t      state, state_nx;
  logic [63:0] work;
  logic [31:0] divisor;
  logic [5:0]  count;

  logic        accept, zdiv, last_step, fits;
  logic [32:0] trial;
  logic [31:0] diff, step_hi, step_lo;

  // One restoring step: the shifted partial remainder needs 33 bits before the compare.
  assign trial     = work[63:31];
  assign fits      = trial >= {1'b0, divisor};
  assign diff      = trial[31:0] - divisor;
  assign step_hi   = fits ? diff : trial[31:0];
  assign step_lo   = {work[30:0], fits};
  assign last_step = (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    zdiv     = 1'b0;
    case (state)
      IDLE: begin
        if (Signal == DIVU) begin
          if (dataB != 32'd0) begin
            accept   = 1'b1;
            state_nx = CALC;
          end else begin
            zdiv = 1'b1;
          end
        end
      end
      CALC:    if (last_step) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work      <= 64'd0;
      divisor   <= 32'd0;
      count     <= 6'd0;
      HiOut     <= 32'd0;
      LoOut     <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        divisor   <= dataB;
        work      <= {32'd0, dataA};
        count     <= 6'd0;
        busy      <= 1'b1;
        divByZero <= 1'b0;
      end else if (zdiv) begin
        HiOut     <= dataA;
        LoOut     <= 32'hFFFF_FFFF;
        divByZero <= 1'b1;
        done      <= 1'b1;
      end
      if (state == CALC) begin
        work  <= {step_hi, step_lo};
        count <= count + 6'd1;
        if (last_step) begin
          HiOut <= step_hi;
          LoOut <= step_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_divu_hilo.sv
// Scoreboarded random/directed bench for divu_hilo against a plain-arithmetic reference.
module tb_divu_hilo;

  localparam logic [5:0] DIVU = 6'b011011;
  localparam logic [5:0] MFHI = 6'b010000;
  localparam logic [5:0] MFLO = 6'b010010;
  localparam logic [5:0] ADD  = 6'b100000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB;
  logic [5:0]  Signal;
  logic [31:0] HiOut, LoOut;
  logic        busy, done, divByZero;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          ncount = 0;
  logic [31:0] last_hi, last_lo;

  divu_hilo #(.DIVU(DIVU), .ITER(32)) dut (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .Signal(Signal),
    .HiOut(HiOut), .LoOut(LoOut), .busy(busy), .done(done), .divByZero(divByZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at negedge %0d", name, act, exp, ncount);
    end
  endtask

  // Monitor: pops one expectation for every done pulse and checks its timing.
  always @(negedge clk) begin
    ncount++;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", HiOut, e.hi);
        chk("lo", LoOut, e.lo);
        chk("dbz", {31'd0, divByZero}, {31'd0, e.dbz});
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("latency", ncount, e.due);
      end
    end else if (sb.size() != 0 && !sb[0].dbz &&
                 ncount >= sb[0].due - 32 && ncount < sb[0].due) begin
      chk("busy_in_calc", {31'd0, busy}, 32'd1);
    end
  end

  function automatic logic [5:0] idle_code();
    logic [5:0] c;
    c = 6'($urandom_range(0, 63));
    if (c == DIVU) c = ADD;
    return c;
  endfunction

  task automatic push(input logic [31:0] a, input logic [31:0] b, input int k);
    exp_t e;
    if (b == 32'd0) begin
      e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1; e.due = k + 2;
    end else begin
      e.hi = a % b; e.lo = a / b; e.dbz = 1'b0; e.due = k + 34;
    end
    last_hi = e.hi;
    last_lo = e.lo;
    sb.push_back(e);
  endtask

  // Issue one DIVU, scramble operands after acceptance, return once a new accept is legal.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    dataA = a; dataB = b; Signal = DIVU;
    push(a, b, ncount);
    @(posedge clk); #1;
    Signal = idle_code();
    dataA = $urandom; dataB = $urandom;
    if (b != 32'd0) repeat (32) @(posedge clk);
  endtask

  initial begin
    logic [31:0] a, b;
    int k, r;
    reset = 1'b1; dataA = 32'd0; dataB = 32'd0; Signal = 6'd0;
    #1;
    chk("rst_hi", HiOut, 32'd0);
    chk("rst_lo", LoOut, 32'd0);
    chk("rst_flags", {29'd0, busy, done, divByZero}, 32'd0);
    #21 reset = 1'b0;

    do_div(32'd100, 32'd7);
    do_div(32'hFFFF_FFFF, 32'd1);
    do_div(32'd3, 32'd10);
    do_div(32'd5, 32'd0);
    do_div(32'd9, 32'd3);

    // DIVU re-issued mid-divide and dataA changed later must not disturb the result.
    @(posedge clk); #1;
    dataA = 32'd100; dataB = 32'd7; Signal = DIVU;
    push(32'd100, 32'd7, ncount);
    @(posedge clk); #1; Signal = ADD;
    repeat (4) @(posedge clk); #1;
    Signal = DIVU; dataA = 32'd50; dataB = 32'd5;
    @(posedge clk); #1; Signal = ADD;
    repeat (4) @(posedge clk); #1;
    dataA = 32'd12345;
    repeat (23) @(posedge clk);

    // DIVU held high: the FIN->IDLE edge must not accept, the next edge must.
    @(posedge clk); #1;
    dataA = 32'd1000; dataB = 32'd9; Signal = DIVU;
    k = ncount;
    push(32'd1000, 32'd9, k);
    push(32'd1000, 32'd9, k + 34);
    repeat (35) @(posedge clk); #1;
    Signal = ADD;
    repeat (32) @(posedge clk);

    // Move-from and ALU codes leave the result registers alone.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      Signal = (i % 3 == 0) ? MFHI : (i % 3 == 1) ? MFLO : ADD;
      dataA = $urandom; dataB = $urandom;
    end
    @(posedge clk); #1;
    chk("hold_hi", HiOut, last_hi);
    chk("hold_lo", LoOut, last_lo);

    // Asynchronous reset mid-divide.
    @(posedge clk); #1;
    dataA = 32'd100; dataB = 32'd7; Signal = DIVU;
    @(posedge clk); #1; Signal = ADD;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_hi", HiOut, 32'd0);
    chk("arst_lo", LoOut, 32'd0);
    chk("arst_flags", {29'd0, busy, done, divByZero}, 32'd0);
    #3 reset = 1'b0;
    do_div(32'd20, 32'd6);

    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 100)) : $urandom;
      if (r == 0)      b = 32'd0;
      else if (r <= 3) b = 32'($urandom_range(1, 15));
      else if (r == 4) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      else             b = $urandom;
      do_div(a, b);
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
